// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if
//   Bundles the two requester ports (CPU MAR/MDR path and debug loader) and
//   the SRAM pin-side signals of the arbiter.
//   slave  : arbiter view (requests in, strobes/results out)
//   master : environment view (requesters, SRAM pins model)
//   Signals:
//     cpu_req/we/addr/wdata, dbg_req/we/addr/wdata : requests, held until done
//     cpu_rdata/cpu_done, dbg_rdata/dbg_done       : results and done pulses
//     busy                                         : arbiter not idle
//     CE/UB/LB/OE/WE                               : active-low SRAM strobes
//     ADDR, Data_out, Data_drive, Data_in          : SRAM address and data path
interface sram_access_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic [15:0] dbg_rdata;
  logic        dbg_done;
  logic        busy;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] Data_out;
  logic        Data_drive;
  logic [15:0] Data_in;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  Data_in,
    output cpu_rdata, cpu_done, dbg_rdata, dbg_done, busy,
    output CE, UB, LB, OE, WE, ADDR, Data_out, Data_drive
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output Data_in,
    input  cpu_rdata, cpu_done, dbg_rdata, dbg_done, busy,
    input  CE, UB, LB, OE, WE, ADDR, Data_out, Data_drive
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares the single off-chip 16-bit SRAM between the LC-3 datapath and the
//   debug/front-panel loader. Requests are sampled only in IDLE; the winner's
//   address, direction and write data are latched, the strobes are held
//   active for WAIT_CYCLES cycles, read data is captured on the last ACCESS
//   edge, and a one-cycle done pulse is returned in DONE.
//   Ports:
//     Clk   : system clock, rising edge
//     Reset : asynchronous, active-high reset
//     bus   : requester and SRAM-side signals (sram_access_arbiter_if.slave)
//   Parameters:
//     WAIT_CYCLES : cycles the strobes stay active per access (1..15)
//     FIXED_PRIO  : 0 = round-robin on ties, 1 = CPU always wins ties
module sram_access_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sram_access_arbiter_if.slave  bus
);

  // busy is bit 0 of the state register, so it comes straight from a flop and
  // cannot glitch on any state transition.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b11
  } state_t;

  localparam logic       GNT_CPU   = 1'b0;
  localparam logic       GNT_DBG   = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_we;
  logic        lat_gnt;
  logic        last_grant;
  logic [15:0] cpu_rdata_q;
  logic [15:0] dbg_rdata_q;
  logic        any_req;
  logic        grant_dbg;
  logic        in_access;
  logic        last_access;

  assign any_req     = bus.cpu_req | bus.dbg_req;
  // DBG wins when it is alone, or on a tie under round-robin after a CPU grant.
  assign grant_dbg   = bus.dbg_req &
                       (~bus.cpu_req | (~FIXED_PRIO & (last_grant == GNT_CPU)));
  assign in_access   = (state == ACCESS);
  assign last_access = in_access & (cnt == 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req)     state_nx = ACCESS;
      ACCESS:  if (last_access) state_nx = DONE;
      DONE:                     state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, including rdata, so a reset
  // mid-access leaves no stale address or data on the pins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_we      <= 1'b0;
      lat_gnt     <= GNT_CPU;
      last_grant  <= GNT_DBG;   // first tie goes to the CPU
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_gnt    <= grant_dbg;
        last_grant <= grant_dbg;
        lat_addr   <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
        lat_wdata  <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        lat_we     <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
        cnt        <= WAIT_INIT;
      end
      if (in_access) cnt <= cnt - 4'd1;
      if (last_access && !lat_we) begin
        if (lat_gnt == GNT_DBG) dbg_rdata_q <= bus.Data_in;
        else                    cpu_rdata_q <= bus.Data_in;
      end
    end
  end

  // Strobes decode from the state register, so an asynchronous reset drops
  // them in the same cycle.
  assign bus.CE         = ~in_access;
  assign bus.UB         = ~in_access;
  assign bus.LB         = ~in_access;
  assign bus.OE         = ~(in_access & ~lat_we);
  assign bus.WE         = ~(in_access &  lat_we);
  assign bus.Data_drive = in_access & lat_we;
  assign bus.Data_out   = lat_wdata;
  assign bus.ADDR       = {4'b0000, lat_addr};
  assign bus.busy       = state[0];
  assign bus.cpu_done   = (state == DONE) & (lat_gnt == GNT_CPU);
  assign bus.dbg_done   = (state == DONE) & (lat_gnt == GNT_DBG);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule
